// File: rtl/pic_interrupt_service_unit_pkg.sv
// Shared constants and types for the PIC interrupt service unit:
// strobe bit indices, OCW2 command encodings and the INTA handshake states.
package pic_pkg;

  localparam int unsigned IR_COUNT          = 8;
  localparam logic [7:0]  RESET_IMR_DEFAULT = 8'hFF;
  localparam logic [2:0]  SPURIOUS_LEVEL    = 3'd7;

  localparam int unsigned ICW1_BIT = 0;
  localparam int unsigned ICW2_BIT = 1;
  localparam int unsigned ICW3_BIT = 2;
  localparam int unsigned ICW4_BIT = 3;

  localparam int unsigned OCW1_BIT = 0;
  localparam int unsigned OCW2_BIT = 1;
  localparam int unsigned OCW3_BIT = 2;

  typedef enum logic [2:0] {
    OCW2_ROT_AEOI_CLR = 3'b000,
    OCW2_NS_EOI       = 3'b001,
    OCW2_NOP          = 3'b010,
    OCW2_SP_EOI       = 3'b011,
    OCW2_ROT_AEOI_SET = 3'b100,
    OCW2_ROT_NS_EOI   = 3'b101,
    OCW2_SET_PRIO     = 3'b110,
    OCW2_ROT_SP_EOI   = 3'b111
  } ocw2_cmd_e;

  typedef enum logic {
    INTA_IDLE,
    INTA_ACK1
  } inta_state_e;

endpackage

// File: rtl/pic_interrupt_service_unit_priority_resolver.sv
// Rotating-priority resolver: highest-priority request bit, whether it
// outranks every in-service level, and the highest in-service level.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [IR_COUNT-1:0] req,
  input  logic [IR_COUNT-1:0] isr,
  input  logic [2:0]          lowest_prio,
  output logic [2:0]          winner,
  output logic                winner_valid,
  output logic [2:0]          isr_top
);

  logic [2:0] idx;
  logic [2:0] win_rank;
  logic [2:0] isr_rank;
  logic       win_found;
  logic       isr_found;

  // Scan starts just above lowest_prio so the first hit is the highest priority.
  always_comb begin
    winner    = '0;
    isr_top   = '0;
    win_rank  = '0;
    isr_rank  = '0;
    win_found = 1'b0;
    isr_found = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < IR_COUNT; k++) begin
      idx = lowest_prio + 3'd1 + 3'(k);
      if (!win_found && req[idx]) begin
        winner    = idx;
        win_rank  = 3'(k);
        win_found = 1'b1;
      end
      if (!isr_found && isr[idx]) begin
        isr_top   = idx;
        isr_rank  = 3'(k);
        isr_found = 1'b1;
      end
    end
    winner_valid = win_found && (!isr_found || (win_rank < isr_rank));
  end

endmodule

// File: rtl/pic_interrupt_service_unit.sv
// PIC interrupt service unit: IRR/ISR/IMR, ICW/OCW2 command handling,
// fully nested priority arbitration and the two-pulse INTA vector sequence.
module pic_interrupt_service_unit
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IR    = 8,
  parameter logic [7:0]  RESET_IMR = RESET_IMR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        icw_stb,
  input  logic [2:0]        ocw_stb,
  input  logic [7:0]        din,
  input  logic [NUM_IR-1:0] ir_in,
  input  logic              inta_pulse,
  output logic              int_out,
  output logic [7:0]        vector_out,
  output logic              vector_valid,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr,
  output logic [NUM_IR-1:0] imr,
  output logic              init_busy
);

  inta_state_e       state, state_next;
  logic [NUM_IR-1:0] ir_q;
  logic [NUM_IR-1:0] irr_next;
  logic [NUM_IR-1:0] isr_clr;
  logic [NUM_IR-1:0] isr_set;
  logic [2:0]        lowest_prio, lowest_prio_next;
  logic [2:0]        lvl;
  logic [4:0]        base;
  logic              level_mode, aeoi, rot_aeoi;
  logic              need_icw3, need_icw4, spurious;
  logic              icw1, ocw2;
  ocw2_cmd_e         ocw2_cmd;
  logic [2:0]        ocw2_level;
  logic              first_ack, second_ack, capture;
  logic [2:0]        arb_winner, eoi_top;
  logic              arb_valid, eoi_valid;
  logic [2:0]        arb_isr_top_unused, eoi_isr_top_unused;
  logic              ocw3_unused;

  assign icw1        = icw_stb[ICW1_BIT];
  assign ocw2        = ocw_stb[OCW2_BIT];
  assign ocw2_cmd    = ocw2_cmd_e'(din[7:5]);
  assign ocw2_level  = din[2:0];
  assign ocw3_unused = ocw_stb[OCW3_BIT];

  pic_priority_resolver u_arb (
    .req          (irr & ~imr),
    .isr          (isr),
    .lowest_prio  (lowest_prio),
    .winner       (arb_winner),
    .winner_valid (arb_valid),
    .isr_top      (arb_isr_top_unused)
  );

  // With an empty in-service input the winner is simply the highest ISR bit.
  pic_priority_resolver u_eoi (
    .req          (isr),
    .isr          ('0),
    .lowest_prio  (lowest_prio),
    .winner       (eoi_top),
    .winner_valid (eoi_valid),
    .isr_top      (eoi_isr_top_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= INTA_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    first_ack  = 1'b0;
    second_ack = 1'b0;
    if (icw1) begin
      state_next = INTA_IDLE;
    end else if (inta_pulse) begin
      case (state)
        INTA_IDLE: begin
          first_ack  = 1'b1;
          state_next = INTA_ACK1;
        end
        INTA_ACK1: begin
          second_ack = 1'b1;
          state_next = INTA_IDLE;
        end
        default: state_next = INTA_IDLE;
      endcase
    end
  end

  assign capture = first_ack & arb_valid;

  always_comb begin
    irr_next = level_mode ? ir_in : (irr | (ir_in & ~ir_q));
    if (capture) irr_next[arb_winner] = 1'b0;
  end

  // Clears are applied before sets, so an INTA capture beats an EOI on the same level.
  always_comb begin
    isr_clr          = '0;
    isr_set          = '0;
    lowest_prio_next = lowest_prio;
    if (ocw2) begin
      case (ocw2_cmd)
        OCW2_NS_EOI:     if (eoi_valid) isr_clr[eoi_top] = 1'b1;
        OCW2_SP_EOI:     if (|isr) isr_clr[ocw2_level] = 1'b1;
        OCW2_ROT_NS_EOI: if (eoi_valid) begin
          isr_clr[eoi_top] = 1'b1;
          lowest_prio_next = eoi_top;
        end
        OCW2_ROT_SP_EOI: if (|isr) begin
          isr_clr[ocw2_level] = 1'b1;
          lowest_prio_next    = ocw2_level;
        end
        OCW2_SET_PRIO:   lowest_prio_next = ocw2_level;
        default: ;
      endcase
    end
    if (second_ack && aeoi && !spurious) begin
      isr_clr[lvl] = 1'b1;
      if (rot_aeoi) lowest_prio_next = lvl;
    end
    if (capture) isr_set[arb_winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irr          <= '0;
      isr          <= '0;
      imr          <= RESET_IMR;
      ir_q         <= '0;
      int_out      <= 1'b0;
      vector_out   <= '0;
      vector_valid <= 1'b0;
      init_busy    <= 1'b0;
      lowest_prio  <= 3'd7;
      base         <= '0;
      level_mode   <= 1'b0;
      aeoi         <= 1'b0;
      rot_aeoi     <= 1'b0;
      need_icw3    <= 1'b0;
      need_icw4    <= 1'b0;
      lvl          <= '0;
      spurious     <= 1'b0;
    end else begin
      ir_q <= ir_in;
      if (icw1) begin
        irr          <= '0;
        isr          <= '0;
        imr          <= '0;
        lowest_prio  <= 3'd7;
        aeoi         <= 1'b0;
        rot_aeoi     <= 1'b0;
        level_mode   <= din[3];
        need_icw3    <= ~din[1];
        need_icw4    <= din[0];
        init_busy    <= 1'b1;
        int_out      <= 1'b0;
        vector_valid <= 1'b0;
      end else begin
        irr          <= irr_next;
        isr          <= (isr & ~isr_clr) | isr_set;
        lowest_prio  <= lowest_prio_next;
        int_out      <= capture ? 1'b0 : (arb_valid & ~init_busy);
        vector_valid <= second_ack;
        if (second_ack) vector_out <= {base, lvl};
        if (first_ack) begin
          lvl      <= capture ? arb_winner : SPURIOUS_LEVEL;
          spurious <= ~arb_valid;
        end
        if (ocw_stb[OCW1_BIT]) imr <= din;
        if (ocw2 && (ocw2_cmd == OCW2_ROT_AEOI_SET)) rot_aeoi <= 1'b1;
        if (ocw2 && (ocw2_cmd == OCW2_ROT_AEOI_CLR)) rot_aeoi <= 1'b0;
        if (icw_stb[ICW2_BIT]) begin
          base <= din[7:3];
          if (!need_icw3 && !need_icw4) init_busy <= 1'b0;
        end
        if (icw_stb[ICW3_BIT] && !need_icw4) init_busy <= 1'b0;
        if (icw_stb[ICW4_BIT]) begin
          aeoi      <= din[1];
          init_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pic_interrupt_service_unit.sv
// Bench for pic_interrupt_service_unit: directed vector table, corner-case
// sequences and a randomized run against a rank-based reference model.
module tb_pic_interrupt_service_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] icw_stb = '0;
  logic [2:0] ocw_stb = '0;
  logic [7:0] din = '0;
  logic [7:0] ir_in = '0;
  logic       inta_pulse = 1'b0;
  logic       int_out, vector_valid, init_busy;
  logic [7:0] vector_out, irr, isr, imr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pic_interrupt_service_unit #(.NUM_IR(8), .RESET_IMR(8'hFF)) dut (
    .clk(clk), .rst(rst), .icw_stb(icw_stb), .ocw_stb(ocw_stb), .din(din),
    .ir_in(ir_in), .inta_pulse(inta_pulse), .int_out(int_out),
    .vector_out(vector_out), .vector_valid(vector_valid),
    .irr(irr), .isr(isr), .imr(imr), .init_busy(init_busy)
  );

  typedef struct {
    logic [7:0] ir;
    logic [3:0] icw;
    logic [2:0] ocw;
    logic [7:0] d;
    logic       ia;
    logic       e_int;
    logic       e_vv;
    logic [7:0] e_vec, e_irr, e_isr, e_imr;
    logic       e_busy;
  } vec_t;
  vec_t tbl[$];

  // reference model state
  logic [7:0] m_irr, m_isr, m_imr, m_irq, m_vec;
  logic [4:0] m_base;
  logic [2:0] m_lvl;
  int         m_lp;
  logic       m_level, m_aeoi, m_rot, m_need3, m_need4, m_busy;
  logic       m_int, m_vv, m_ack, m_spur;

  function automatic int rank(input int i, input int lp);
    return (i - lp - 1 + 16) % 8;
  endfunction

  function automatic int top(input logic [7:0] v, input int lp);
    int best = -1;
    for (int i = 0; i < 8; i++)
      if (v[i] && (best < 0 || rank(i, lp) < rank(best, lp))) best = i;
    return best;
  endfunction

  task automatic model_step();
    int c, h, l, nlp;
    bit ok;
    logic [7:0] nirr, nisr;
    if (rst) begin
      m_irr = '0; m_isr = '0; m_imr = 8'hFF; m_irq = '0; m_vec = '0; m_base = '0;
      m_lvl = '0; m_lp = 7; m_level = 0; m_aeoi = 0; m_rot = 0; m_need3 = 0;
      m_need4 = 0; m_busy = 0; m_int = 0; m_vv = 0; m_ack = 0; m_spur = 0;
      return;
    end
    m_irq_prev_update: begin end
    if (icw_stb[0]) begin
      m_irr = '0; m_isr = '0; m_imr = '0; m_lp = 7; m_aeoi = 0; m_rot = 0;
      m_level = din[3]; m_need3 = ~din[1]; m_need4 = din[0]; m_busy = 1;
      m_int = 0; m_vv = 0; m_ack = 0; m_irq = ir_in;
      return;
    end
    c = top(m_irr & ~m_imr, m_lp);
    h = top(m_isr, m_lp);
    ok = (c >= 0) && (h < 0 || rank(c, m_lp) < rank(h, m_lp));
    nirr = m_level ? ir_in : (m_irr | (ir_in & ~m_irq));
    nisr = m_isr;
    nlp = m_lp;
    l = int'(din[2:0]);
    if (ocw_stb[1] && m_isr != 0) begin
      case (din[7:5])
        3'd1: nisr[h] = 1'b0;
        3'd3: nisr[l] = 1'b0;
        3'd5: begin nisr[h] = 1'b0; nlp = h; end
        3'd7: begin nisr[l] = 1'b0; nlp = l; end
        default: ;
      endcase
    end
    if (ocw_stb[1] && din[7:5] == 3'd6) nlp = l;
    m_int = ok && !m_busy;
    m_vv = 0;
    if (inta_pulse) begin
      if (!m_ack) begin
        m_ack = 1;
        if (ok) begin
          m_lvl = 3'(c); m_spur = 0; nisr[c] = 1'b1; nirr[c] = 1'b0; m_int = 0;
        end else begin
          m_lvl = 3'd7; m_spur = 1;
        end
      end else begin
        m_ack = 0; m_vv = 1; m_vec = {m_base, m_lvl};
        if (m_aeoi && !m_spur) begin
          nisr[m_lvl] = 1'b0;
          if (m_rot) nlp = int'(m_lvl);
        end
      end
    end
    m_irr = nirr; m_isr = nisr; m_lp = nlp; m_irq = ir_in;
    if (ocw_stb[0]) m_imr = din;
    if (ocw_stb[1] && din[7:5] == 3'd4) m_rot = 1;
    if (ocw_stb[1] && din[7:5] == 3'd0) m_rot = 0;
    if (icw_stb[1]) begin
      m_base = din[7:3];
      if (!m_need3 && !m_need4) m_busy = 0;
    end
    if (icw_stb[2] && !m_need4) m_busy = 0;
    if (icw_stb[3]) begin m_aeoi = din[1]; m_busy = 0; end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step(input logic s_rst, input logic [7:0] s_ir, input logic [3:0] s_icw,
                      input logic [2:0] s_ocw, input logic [7:0] s_d, input logic s_ia);
    @(negedge clk);
    rst = s_rst; ir_in = s_ir; icw_stb = s_icw; ocw_stb = s_ocw; din = s_d; inta_pulse = s_ia;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".int"},  8'(int_out),      8'(m_int));
    chk({tag, ".vv"},   8'(vector_valid), 8'(m_vv));
    chk({tag, ".vec"},  vector_out,       m_vec);
    chk({tag, ".irr"},  irr,              m_irr);
    chk({tag, ".isr"},  isr,              m_isr);
    chk({tag, ".imr"},  imr,              m_imr);
    chk({tag, ".busy"}, 8'(init_busy),    8'(m_busy));
  endtask

  task automatic add(input logic [7:0] ir, input logic [3:0] icw, input logic [2:0] ocw,
                     input logic [7:0] d, input logic ia, input logic e_int, input logic e_vv,
                     input logic [7:0] e_vec, input logic [7:0] e_irr, input logic [7:0] e_isr,
                     input logic [7:0] e_imr, input logic e_busy);
    vec_t r;
    r.ir = ir; r.icw = icw; r.ocw = ocw; r.d = d; r.ia = ia; r.e_int = e_int; r.e_vv = e_vv;
    r.e_vec = e_vec; r.e_irr = e_irr; r.e_isr = e_isr; r.e_imr = e_imr; r.e_busy = e_busy;
    tbl.push_back(r);
  endtask

  initial begin
    logic [7:0] ir_cur;
    logic [7:0] d;
    logic [3:0] icw;
    logic [2:0] ocw;
    logic       ia, r_rst;
    int         r;

    //   ir     icw   ocw    din   ia  int vv  vec    irr    isr    imr   busy
    add(8'h00, 4'h1, 3'h0, 8'h13, 0,  0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    add(8'h00, 4'h2, 3'h0, 8'h40, 0,  0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    add(8'h00, 4'h8, 3'h0, 8'h01, 0,  0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(8'h08, 4'h0, 3'h0, 8'h00, 0,  0, 0, 8'h00, 8'h08, 8'h00, 8'h00, 0);
    add(8'h08, 4'h0, 3'h0, 8'h00, 0,  1, 0, 8'h00, 8'h08, 8'h00, 8'h00, 0);
    add(8'h08, 4'h0, 3'h0, 8'h00, 1,  0, 0, 8'h00, 8'h00, 8'h08, 8'h00, 0);
    add(8'h08, 4'h0, 3'h0, 8'h00, 1,  0, 1, 8'h43, 8'h00, 8'h08, 8'h00, 0);
    add(8'h08, 4'h0, 3'h0, 8'h00, 0,  0, 0, 8'h43, 8'h00, 8'h08, 8'h00, 0);
    add(8'h08, 4'h0, 3'h2, 8'h20, 0,  0, 0, 8'h43, 8'h00, 8'h00, 8'h00, 0);
    add(8'h00, 4'h0, 3'h0, 8'h00, 0,  0, 0, 8'h43, 8'h00, 8'h00, 8'h00, 0);
    add(8'h24, 4'h0, 3'h0, 8'h00, 0,  0, 0, 8'h43, 8'h24, 8'h00, 8'h00, 0);
    add(8'h24, 4'h0, 3'h0, 8'h00, 0,  1, 0, 8'h43, 8'h24, 8'h00, 8'h00, 0);
    add(8'h24, 4'h0, 3'h0, 8'h00, 1,  0, 0, 8'h43, 8'h20, 8'h04, 8'h00, 0);
    add(8'h24, 4'h0, 3'h0, 8'h00, 1,  0, 1, 8'h42, 8'h20, 8'h04, 8'h00, 0);
    add(8'h24, 4'h0, 3'h2, 8'h20, 0,  0, 0, 8'h42, 8'h20, 8'h00, 8'h00, 0);
    add(8'h24, 4'h0, 3'h0, 8'h00, 0,  1, 0, 8'h42, 8'h20, 8'h00, 8'h00, 0);
    add(8'h24, 4'h0, 3'h0, 8'h00, 1,  0, 0, 8'h42, 8'h00, 8'h20, 8'h00, 0);
    add(8'h24, 4'h0, 3'h0, 8'h00, 1,  0, 1, 8'h45, 8'h00, 8'h20, 8'h00, 0);
    add(8'h24, 4'h0, 3'h2, 8'h20, 0,  0, 0, 8'h45, 8'h00, 8'h00, 8'h00, 0);
    add(8'h00, 4'h0, 3'h1, 8'h04, 0,  0, 0, 8'h45, 8'h00, 8'h00, 8'h04, 0);
    add(8'h04, 4'h0, 3'h0, 8'h00, 0,  0, 0, 8'h45, 8'h04, 8'h00, 8'h04, 0);
    add(8'h04, 4'h0, 3'h0, 8'h00, 0,  0, 0, 8'h45, 8'h04, 8'h00, 8'h04, 0);
    add(8'h04, 4'h0, 3'h1, 8'h00, 0,  0, 0, 8'h45, 8'h04, 8'h00, 8'h00, 0);
    add(8'h04, 4'h0, 3'h0, 8'h00, 0,  1, 0, 8'h45, 8'h04, 8'h00, 8'h00, 0);
    add(8'h04, 4'h0, 3'h0, 8'h00, 1,  0, 0, 8'h45, 8'h00, 8'h04, 8'h00, 0);
    add(8'h04, 4'h0, 3'h0, 8'h00, 1,  0, 1, 8'h42, 8'h00, 8'h04, 8'h00, 0);
    add(8'h04, 4'h0, 3'h2, 8'h20, 0,  0, 0, 8'h42, 8'h00, 8'h00, 8'h00, 0);
    add(8'h00, 4'h0, 3'h2, 8'hC4, 0,  0, 0, 8'h42, 8'h00, 8'h00, 8'h00, 0);
    add(8'h42, 4'h0, 3'h0, 8'h00, 0,  0, 0, 8'h42, 8'h42, 8'h00, 8'h00, 0);
    add(8'h42, 4'h0, 3'h0, 8'h00, 0,  1, 0, 8'h42, 8'h42, 8'h00, 8'h00, 0);
    add(8'h42, 4'h0, 3'h0, 8'h00, 1,  0, 0, 8'h42, 8'h02, 8'h40, 8'h00, 0);
    add(8'h42, 4'h0, 3'h0, 8'h00, 1,  0, 1, 8'h46, 8'h02, 8'h40, 8'h00, 0);
    add(8'h42, 4'h0, 3'h2, 8'h20, 0,  0, 0, 8'h46, 8'h02, 8'h00, 8'h00, 0);
    add(8'h42, 4'h0, 3'h0, 8'h00, 0,  1, 0, 8'h46, 8'h02, 8'h00, 8'h00, 0);
    add(8'h42, 4'h0, 3'h0, 8'h00, 1,  0, 0, 8'h46, 8'h00, 8'h02, 8'h00, 0);
    add(8'h42, 4'h0, 3'h0, 8'h00, 1,  0, 1, 8'h41, 8'h00, 8'h02, 8'h00, 0);
    add(8'h42, 4'h0, 3'h2, 8'h20, 0,  0, 0, 8'h41, 8'h00, 8'h00, 8'h00, 0);
    add(8'h00, 4'h8, 3'h0, 8'h03, 0,  0, 0, 8'h41, 8'h00, 8'h00, 8'h00, 0);
    add(8'h00, 4'h0, 3'h2, 8'h80, 0,  0, 0, 8'h41, 8'h00, 8'h00, 8'h00, 0);
    add(8'h08, 4'h0, 3'h0, 8'h00, 0,  0, 0, 8'h41, 8'h08, 8'h00, 8'h00, 0);
    add(8'h08, 4'h0, 3'h0, 8'h00, 0,  1, 0, 8'h41, 8'h08, 8'h00, 8'h00, 0);
    add(8'h08, 4'h0, 3'h0, 8'h00, 1,  0, 0, 8'h41, 8'h00, 8'h08, 8'h00, 0);
    add(8'h08, 4'h0, 3'h0, 8'h00, 1,  0, 1, 8'h43, 8'h00, 8'h00, 8'h00, 0);
    add(8'h00, 4'h0, 3'h0, 8'h00, 0,  0, 0, 8'h43, 8'h00, 8'h00, 8'h00, 0);
    add(8'h11, 4'h0, 3'h0, 8'h00, 0,  0, 0, 8'h43, 8'h11, 8'h00, 8'h00, 0);
    add(8'h11, 4'h0, 3'h0, 8'h00, 0,  1, 0, 8'h43, 8'h11, 8'h00, 8'h00, 0);
    add(8'h11, 4'h0, 3'h0, 8'h00, 1,  0, 0, 8'h43, 8'h01, 8'h10, 8'h00, 0);
    add(8'h11, 4'h0, 3'h0, 8'h00, 1,  0, 1, 8'h44, 8'h01, 8'h00, 8'h00, 0);
    add(8'h11, 4'h0, 3'h0, 8'h00, 0,  1, 0, 8'h44, 8'h01, 8'h00, 8'h00, 0);
    add(8'h11, 4'h0, 3'h0, 8'h00, 1,  0, 0, 8'h44, 8'h00, 8'h01, 8'h00, 0);
    add(8'h11, 4'h0, 3'h0, 8'h00, 1,  0, 1, 8'h40, 8'h00, 8'h00, 8'h00, 0);
    add(8'h11, 4'h0, 3'h0, 8'h00, 1,  0, 0, 8'h40, 8'h00, 8'h00, 8'h00, 0);
    add(8'h11, 4'h0, 3'h0, 8'h00, 1,  0, 1, 8'h47, 8'h00, 8'h00, 8'h00, 0);

    // reset state
    step(1, 8'h00, 4'h0, 3'h0, 8'h00, 0);
    step(1, 8'h00, 4'h0, 3'h0, 8'h00, 0);
    chk("rst.irr", irr, 8'h00);
    chk("rst.isr", isr, 8'h00);
    chk("rst.imr", imr, 8'hFF);
    chk("rst.int", 8'(int_out), 8'h00);
    chk("rst.vv", 8'(vector_valid), 8'h00);
    chk("rst.vec", vector_out, 8'h00);
    chk("rst.busy", 8'(init_busy), 8'h00);

    foreach (tbl[i]) begin
      step(0, tbl[i].ir, tbl[i].icw, tbl[i].ocw, tbl[i].d, tbl[i].ia);
      chk($sformatf("row%0d.int", i),  8'(int_out),      8'(tbl[i].e_int));
      chk($sformatf("row%0d.vv", i),   8'(vector_valid), 8'(tbl[i].e_vv));
      chk($sformatf("row%0d.vec", i),  vector_out,       tbl[i].e_vec);
      chk($sformatf("row%0d.irr", i),  irr,              tbl[i].e_irr);
      chk($sformatf("row%0d.isr", i),  isr,              tbl[i].e_isr);
      chk($sformatf("row%0d.imr", i),  imr,              tbl[i].e_imr);
      chk($sformatf("row%0d.busy", i), 8'(init_busy),    8'(tbl[i].e_busy));
    end

    // specific EOI and INTA capture on the same level: the set wins
    step(1, 8'h00, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h00, 4'h1, 3'h0, 8'h13, 0);
    step(0, 8'h00, 4'h2, 3'h0, 8'h40, 0);
    step(0, 8'h00, 4'h8, 3'h0, 8'h01, 0);
    step(0, 8'h20, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h20, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h20, 4'h0, 3'h0, 8'h00, 1);
    step(0, 8'h20, 4'h0, 3'h0, 8'h00, 1);
    chk("seq_a.isr5", isr, 8'h20);
    step(0, 8'h24, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h24, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h24, 4'h0, 3'h2, 8'h62, 1);
    chk("seq_a.setwins", isr, 8'h24);
    cmp_model("seq_a");
    step(0, 8'h24, 4'h0, 3'h0, 8'h00, 1);
    chk("seq_a.vec", vector_out, 8'h42);

    // OCW1 in the same cycle as the first INTA: arbitration uses the old mask
    step(0, 8'h24, 4'h0, 3'h2, 8'h20, 0);
    step(0, 8'h24, 4'h0, 3'h2, 8'h20, 0);
    chk("seq_b.isr_clr", isr, 8'h00);
    step(0, 8'h00, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h04, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h04, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h04, 4'h0, 3'h1, 8'h04, 1);
    chk("seq_b.isr", isr, 8'h04);
    chk("seq_b.imr", imr, 8'h04);
    step(0, 8'h04, 4'h0, 3'h0, 8'h00, 1);
    chk("seq_b.vec", vector_out, 8'h42);
    cmp_model("seq_b");

    // ICW1 overrides an INTA and returns the handshake to idle
    step(0, 8'h04, 4'h0, 3'h2, 8'h20, 0);
    step(0, 8'h00, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h08, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h08, 4'h0, 3'h0, 8'h00, 0);
    step(0, 8'h08, 4'h0, 3'h0, 8'h00, 1);
    chk("seq_c.isr3", isr, 8'h08);
    step(0, 8'h08, 4'h1, 3'h0, 8'h13, 1);
    chk("seq_c.isr", isr, 8'h00);
    chk("seq_c.busy", 8'(init_busy), 8'h01);
    step(0, 8'h08, 4'h0, 3'h0, 8'h00, 1);
    chk("seq_c.vv0", 8'(vector_valid), 8'h00);
    step(0, 8'h08, 4'h0, 3'h0, 8'h00, 1);
    chk("seq_c.spurious", vector_out, 8'h47);
    chk("seq_c.vv1", 8'(vector_valid), 8'h01);
    cmp_model("seq_c");

    ir_cur = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if ($urandom_range(0, 3) == 0) ir_cur = ir_cur ^ 8'(1 << $urandom_range(0, 7));
      icw = '0; ocw = '0; ia = 1'b0; r_rst = 1'b0;
      d = 8'($urandom);
      if (r < 40 || (m_int && r < 100)) ia = 1'b1;
      else if (r < 130) begin
        ocw = 3'b010;
        d = {3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))};
      end else if (r < 140) begin
        ocw = 3'b001;
        d = 8'($urandom) & 8'($urandom) & 8'($urandom);
      end else if (r < 143) icw = 4'b0001;
      else if (r < 155) icw = 4'(1 << $urandom_range(1, 3));
      else if (r == 199) r_rst = 1'b1;
      step(r_rst, ir_cur, icw, ocw, d, ia);
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
